// File: rtl/herm_inserter.sv
`default_nettype none
// ============================================================================
// Module   : herm_inserter
// Function : Ping-pong buffered Hermitian-symmetry frame builder for a
//            real-output IFFT (DC, active bins, guard zeros, conjugate mirror).
// Revision : 1.0 - initial release
// ============================================================================
module herm_inserter #(
  parameter int FFT_POINT      = 64,
  parameter int ACTIVE_SUBCARR = 28,
  parameter int SYMBOL_NUM     = 8,
  parameter int IQ_W           = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                abort,
  input  logic [2*IQ_W-1:0]   s_data,
  input  logic                s_valid,
  output logic                s_ready,
  output logic [2*IQ_W-1:0]   m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  output logic                m_frame_last,
  output logic                frame_done,
  output logic                busy
);

  localparam int c_dw    = 2 * IQ_W;
  localparam int c_bin_w = $clog2(FFT_POINT);
  localparam int c_aw    = (ACTIVE_SUBCARR > 1) ? $clog2(ACTIVE_SUBCARR) : 1;
  localparam int c_sw    = (SYMBOL_NUM > 1) ? $clog2(SYMBOL_NUM) : 1;

  localparam logic [c_bin_w-1:0] c_last_bin = c_bin_w'(FFT_POINT - 1);
  localparam logic [c_bin_w-1:0] c_act      = c_bin_w'(ACTIVE_SUBCARR);
  localparam logic [c_bin_w-1:0] c_mirror   = c_bin_w'(FFT_POINT - ACTIVE_SUBCARR);
  localparam logic [c_aw-1:0]    c_wr_last  = c_aw'(ACTIVE_SUBCARR - 1);
  localparam logic [c_sw-1:0]    c_sym_last = c_sw'(SYMBOL_NUM - 1);
  localparam logic [IQ_W-1:0]    c_im_min   = {1'b1, {(IQ_W-1){1'b0}}};
  localparam logic [IQ_W-1:0]    c_im_max   = {1'b0, {(IQ_W-1){1'b1}}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  logic [c_dw-1:0]    r_mem [2][ACTIVE_SUBCARR];
  state_t             r_state, w_state_nxt;
  logic [1:0]         r_full, w_full_nxt;
  logic               r_wr_bank, r_rd_bank, r_rdy_en;
  logic [c_aw-1:0]    r_wr_cnt;
  logic [c_bin_w-1:0] r_bin, w_bin_nxt, w_bin_inc;
  logic [c_sw-1:0]    r_sym_cnt;
  logic [c_dw-1:0]    r_m_data, w_data_nxt, w_map_data, w_rd_word;
  logic               r_m_valid, w_valid_nxt;
  logic               r_m_last, w_last_nxt;
  logic               r_m_flast, w_flast_nxt;
  logic               r_frame_done;
  logic               w_in_acc, w_fill_last, w_out_acc, w_sym_end, w_other_full;
  logic [c_aw-1:0]    w_rd_idx;
  logic               w_rd_zero, w_rd_conj;
  logic [IQ_W-1:0]    w_im, w_im_neg;

  // s_ready stays low until the first clock after reset release
  assign s_ready      = r_rdy_en & ~r_full[r_wr_bank];
  assign w_in_acc     = s_valid & s_ready;
  assign w_fill_last  = w_in_acc & (r_wr_cnt == c_wr_last);
  assign w_out_acc    = r_m_valid & m_ready;
  assign w_bin_inc    = r_bin + c_bin_w'(1);
  assign w_other_full = r_full[~r_rd_bank] | (w_fill_last & (r_wr_bank != r_rd_bank));

  assign m_data       = r_m_data;
  assign m_valid      = r_m_valid;
  assign m_last       = r_m_last;
  assign m_frame_last = r_m_flast;
  assign frame_done   = r_frame_done;
  assign busy         = (|r_full) | (r_wr_cnt != '0) | r_m_valid;

  // Bin map for the bin about to be presented
  always_comb begin
    w_rd_idx  = '0;
    w_rd_zero = 1'b1;
    w_rd_conj = 1'b0;
    if ((w_bin_inc != '0) && (w_bin_inc <= c_act)) begin
      w_rd_idx  = c_aw'(w_bin_inc - c_bin_w'(1));
      w_rd_zero = 1'b0;
    end else if (w_bin_inc >= c_mirror) begin
      w_rd_idx  = c_aw'(c_last_bin - w_bin_inc);
      w_rd_zero = 1'b0;
      w_rd_conj = 1'b1;
    end
  end

  assign w_rd_word  = r_mem[r_rd_bank][w_rd_idx];
  assign w_im       = w_rd_word[IQ_W-1:0];
  assign w_im_neg   = (w_im == c_im_min) ? c_im_max : -w_im;
  assign w_map_data = w_rd_zero ? '0 :
                      w_rd_conj ? {w_rd_word[c_dw-1:IQ_W], w_im_neg} : w_rd_word;

  // Fill and emit always target different banks, so both updates can land together
  always_comb begin
    w_full_nxt = r_full;
    if (w_fill_last) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_sym_end)   w_full_nxt[r_rd_bank] = 1'b0;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_m_valid;
    w_data_nxt  = r_m_data;
    w_last_nxt  = r_m_last;
    w_flast_nxt = r_m_flast;
    w_bin_nxt   = r_bin;
    w_sym_end   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_state_nxt = EMIT;
          w_valid_nxt = 1'b1;
          w_data_nxt  = '0;
          w_last_nxt  = 1'b0;
          w_flast_nxt = 1'b0;
          w_bin_nxt   = '0;
        end
      end
      EMIT: begin
        if (w_out_acc) begin
          if (r_bin == c_last_bin) begin
            w_sym_end   = 1'b1;
            w_bin_nxt   = '0;
            w_data_nxt  = '0;
            w_last_nxt  = 1'b0;
            w_flast_nxt = 1'b0;
            if (!w_other_full) begin
              w_state_nxt = IDLE;
              w_valid_nxt = 1'b0;
            end
          end else begin
            w_bin_nxt   = w_bin_inc;
            w_data_nxt  = w_map_data;
            w_last_nxt  = (w_bin_inc == c_last_bin);
            w_flast_nxt = (w_bin_inc == c_last_bin) && (r_sym_cnt == c_sym_last);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_full       <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_rdy_en     <= 1'b0;
      r_wr_cnt     <= '0;
      r_bin        <= '0;
      r_sym_cnt    <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_flast    <= 1'b0;
      r_frame_done <= 1'b0;
    end else if (abort) begin
      r_state      <= IDLE;
      r_full       <= '0;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_rdy_en     <= 1'b1;
      r_wr_cnt     <= '0;
      r_bin        <= '0;
      r_sym_cnt    <= '0;
      r_m_data     <= '0;
      r_m_valid    <= 1'b0;
      r_m_last     <= 1'b0;
      r_m_flast    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_rdy_en     <= 1'b1;
      r_state      <= w_state_nxt;
      r_full       <= w_full_nxt;
      r_bin        <= w_bin_nxt;
      r_m_data     <= w_data_nxt;
      r_m_valid    <= w_valid_nxt;
      r_m_last     <= w_last_nxt;
      r_m_flast    <= w_flast_nxt;
      r_frame_done <= w_out_acc & r_m_flast;
      if (w_in_acc) begin
        r_wr_cnt <= w_fill_last ? '0 : r_wr_cnt + c_aw'(1);
        if (w_fill_last) r_wr_bank <= ~r_wr_bank;
      end
      if (w_sym_end) begin
        r_rd_bank <= ~r_rd_bank;
        r_sym_cnt <= (r_sym_cnt == c_sym_last) ? '0 : r_sym_cnt + c_sw'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_acc && !abort) r_mem[r_wr_bank][r_wr_cnt] <= s_data;
  end

endmodule
`default_nettype wire
